// File: rtl/anc_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : anc_stream_pkg                                     |
// | Description : Shared defaults, FSM state type and width helper   |
// |               for the ANC stream sequencer.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package anc_stream_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_CH    = 2;
  localparam int DEF_K     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Channel-select width; a single channel still needs a one-bit port
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anc_sample_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : anc_sample_ram                                     |
// | Description : CH x DEPTH x W sample store, one write port and    |
// |               one synchronous read port returning all channels.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module anc_sample_ram
  import anc_stream_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CH    = DEF_CH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = ch_width(CH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [CW-1:0]   wch,
  input  logic [AW-1:0]   waddr,
  input  logic [W-1:0]    wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [CH*W-1:0] rdata
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;

    // Per-channel write and registered read; contents are never reset
    always_ff @(posedge clk) begin
      if (we && (wch == CW'(c))) mem[waddr] <= wdata;
      if (re) rd_q <= mem[raddr];
    end

    assign rdata[c*W +: W] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/anc_stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : anc_stream_sequencer                               |
// | Description : Plays stored reference/error samples to the ANC    |
// |               datapath at one sample every K clocks and counts   |
// |               the results that come back.                        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module anc_stream_sequencer
  import anc_stream_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CH    = DEF_CH,
  parameter int K     = DEF_K,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = ch_width(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_en,
  input  logic [CW-1:0]   ld_ch,
  input  logic [AW-1:0]   ld_addr,
  input  logic [W-1:0]    ld_data,
  input  logic            start,
  input  logic            loop,
  input  logic [AW:0]     num_samples,
  input  logic            abort,
  input  logic            res_valid,
  output logic            smp_valid,
  output logic [CH*W-1:0] smp_data,
  output logic [AW-1:0]   smp_idx,
  output logic            busy,
  output logic            done,
  output logic            ld_err,
  output logic [AW:0]     res_cnt
);

  localparam int          PW      = $clog2(K);
  localparam logic [PW-1:0] PH_LAST = PW'(K - 1);
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic            issue_q, issue_d;
  logic            loop_q, loop_d;
  logic [AW:0]     len_q, len_d;
  logic            pend_q, pend_d;
  logic            pend_last_q, pend_last_d;
  logic [AW-1:0]   pend_idx_q, pend_idx_d;
  logic            smp_valid_q, smp_valid_d;
  logic [CH*W-1:0] smp_data_q, smp_data_d;
  logic [AW-1:0]   smp_idx_q, smp_idx_d;
  logic [AW:0]     res_cnt_q, res_cnt_d;
  logic            ld_err_q, ld_err_d;

  logic            idle_like;
  logic            busy_int;
  logic            ld_ch_ok;
  logic            wr_en;
  logic            rd_fire;
  logic            rd_last;
  logic            start_ok;
  logic [AW:0]     len_sel;
  logic [CH*W-1:0] ram_rdata;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_int  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ld_ch_ok  = (int'(ld_ch) < CH);
  assign wr_en     = ld_en && ld_ch_ok && idle_like;
  // A read is launched on phase 0 so the strobe lands two clocks later
  assign rd_fire   = (state_q == ST_RUN) && issue_q && (phase_q == '0);
  assign rd_last   = ({1'b0, rd_idx_q} == (len_q - 1'b1));
  assign start_ok  = idle_like && start && !abort;
  assign len_sel   = ((num_samples == '0) || (num_samples > DEPTH_N)) ? DEPTH_N : num_samples;

  anc_sample_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .CH    (CH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .wch   (ld_ch),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rd_fire),
    .raddr (rd_idx_q),
    .rdata (ram_rdata)
  );

  // Next-state, read sequencing, result counting and load-error tracking
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rd_idx_d    = rd_idx_q;
    issue_d     = issue_q;
    loop_d      = loop_q;
    len_d       = len_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    pend_idx_d  = pend_idx_q;
    smp_valid_d = pend_q;
    smp_data_d  = pend_q ? ram_rdata : '0;
    smp_idx_d   = pend_q ? pend_idx_q : '0;
    res_cnt_d   = res_cnt_q;
    ld_err_d    = ld_err_q;

    if (busy_int && ld_en && ld_ch_ok) ld_err_d = 1'b1;
    if (busy_int && res_valid && (res_cnt_q != CNT_MAX)) res_cnt_d = res_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d   = ST_RUN;
          loop_d    = loop;
          len_d     = len_sel;
          res_cnt_d = '0;
          ld_err_d  = 1'b0;
          phase_d   = '0;
          rd_idx_d  = '0;
          issue_d   = 1'b1;
        end
      end
      ST_RUN: begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (rd_fire) begin
          pend_d      = 1'b1;
          pend_idx_d  = rd_idx_q;
          pend_last_d = rd_last && !loop_q;
          if (rd_last) begin
            rd_idx_d = '0;
            issue_d  = loop_q;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
        if (pend_q && pend_last_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_cnt_q == len_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything except the result count, which is held
    if (abort) begin
      state_d     = ST_IDLE;
      phase_d     = '0;
      issue_d     = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      smp_valid_d = 1'b0;
      smp_data_d  = '0;
      smp_idx_d   = '0;
      res_cnt_d   = res_cnt_q;
    end
  end

  // State and registered outputs; reset leaves the sample memory alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      rd_idx_q    <= '0;
      issue_q     <= 1'b0;
      loop_q      <= 1'b0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_idx_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      smp_idx_q   <= '0;
      res_cnt_q   <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rd_idx_q    <= rd_idx_d;
      issue_q     <= issue_d;
      loop_q      <= loop_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_idx_q  <= pend_idx_d;
      smp_valid_q <= smp_valid_d;
      smp_data_q  <= smp_data_d;
      smp_idx_q   <= smp_idx_d;
      res_cnt_q   <= res_cnt_d;
      ld_err_q    <= ld_err_d;
    end
  end

  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_idx   = smp_idx_q;
  assign busy      = busy_int;
  assign done      = (state_q == ST_DONE);
  assign ld_err    = ld_err_q;
  assign res_cnt   = res_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_anc_stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_anc_stream_sequencer                            |
// | Description : Self-checking bench for anc_stream_sequencer with  |
// |               W=32, DEPTH=8, CH=2, K=4.                          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_anc_stream_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int CH    = 2;
  localparam int K     = 4;

  logic        clk;
  logic        rst_n;
  logic        ld_en;
  logic [0:0]  ld_ch;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic        start;
  logic        loop;
  logic [3:0]  num_samples;
  logic        abort;
  logic        res_valid;
  logic        smp_valid;
  logic [63:0] smp_data;
  logic [2:0]  smp_idx;
  logic        busy;
  logic        done;
  logic        ld_err;
  logic [3:0]  res_cnt;

  logic [31:0] mem_m [0:1][0:7];
  int total = 0;
  int bad   = 0;

  anc_stream_sequencer #(.W(W), .DEPTH(DEPTH), .CH(CH), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_ch(ld_ch), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .loop(loop), .num_samples(num_samples),
    .abort(abort), .res_valid(res_valid), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_idx(smp_idx), .busy(busy), .done(done), .ld_err(ld_err), .res_cnt(res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int n);
    return (n == 0 || n > DEPTH) ? DEPTH : n;
  endfunction

  // Expected {valid, idx, data} c cycles after the start edge
  function automatic logic [67:0] exp_smp(input int c, input int n, input bit lp);
    logic [67:0] r;
    int s;
    r = '0;
    if (c >= 2 && ((c - 2) % K) == 0) begin
      s = (c - 2) / K;
      if (lp || s < n) begin
        s = s % n;
        r = {1'b1, 3'(s), mem_m[1][s], mem_m[0][s]};
      end
    end
    return r;
  endfunction

  task automatic load_pattern(input bit rnd);
    logic [31:0] d;
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < DEPTH; i++) begin
        d = rnd ? $urandom : ((ch == 0) ? 32'(i + 1) : 32'(256 + i));
        ld_en = 1'b1; ld_ch = 1'(ch); ld_addr = 3'(i); ld_data = d;
        step();
        mem_m[ch][i] = d;
      end
    end
    ld_en = 1'b0;
  endtask

  // Leaves the bench at cycle 0 (just after the start edge); loop and
  // num_samples are scrambled afterwards since they must have been captured
  task automatic start_run(input int num, input bit lp);
    start = 1'b1; loop = lp; num_samples = 4'(num);
    step();
    start = 1'b0; loop = ~lp; num_samples = 4'($urandom_range(0, 15));
  endtask

  task automatic abort_now();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt} !== '0)
      begin bad++; $display("FAIL reset_hold got=%h exp=0", {smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt}); end
    rst_n = 1'b1;
    step();
    total++;
    if ({smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt} !== '0)
      begin bad++; $display("FAIL reset_release got=%h exp=0", {smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt}); end
  endtask

  task automatic test_playback();
    load_pattern(1'b0);
    start_run(8, 1'b0);
    for (int c = 0; c <= 34; c++) begin
      total++;
      if ({smp_valid, smp_idx, smp_data, busy, done} !== {exp_smp(c, 8, 1'b0), 1'b1, 1'b0})
        begin bad++; $display("FAIL play c=%0d got=%h exp=%h", c, {smp_valid, smp_idx, smp_data, busy, done}, {exp_smp(c, 8, 1'b0), 1'b1, 1'b0}); end
      if (c == 30) begin
        total++;
        if (smp_data !== {32'h107, 32'h8})
          begin bad++; $display("FAIL play_last got=%h exp=%h", smp_data, {32'h107, 32'h8}); end
      end
      if (c < 34) step();
    end
  endtask

  task automatic test_results();
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      total++;
      if ({res_cnt, busy, done} !== {4'(i + 1), 1'b1, 1'b0})
        begin bad++; $display("FAIL res_cnt i=%0d got=%h exp=%h", i, {res_cnt, busy, done}, {4'(i + 1), 1'b1, 1'b0}); end
      if (i < 7) repeat ($urandom_range(0, 2)) step();
    end
    step();
    total++;
    if ({res_cnt, busy, done} !== {4'd8, 1'b0, 1'b1})
      begin bad++; $display("FAIL done got=%h exp=%h", {res_cnt, busy, done}, {4'd8, 1'b0, 1'b1}); end
  endtask

  task automatic test_loop();
    int strobes;
    int res_exp;
    strobes = 0;
    res_exp = 0;
    load_pattern(1'b1);
    start_run(0, 1'b1);
    for (int c = 0; c <= 80; c++) begin
      total++;
      if ({smp_valid, smp_idx, smp_data, busy, done, res_cnt} !== {exp_smp(c, 8, 1'b1), 1'b1, 1'b0, 4'(res_exp)})
        begin bad++; $display("FAIL loop c=%0d got=%h exp=%h", c, {smp_valid, smp_idx, smp_data, busy, done, res_cnt}, {exp_smp(c, 8, 1'b1), 1'b1, 1'b0, 4'(res_exp)}); end
      if (smp_valid === 1'b1) strobes++;
      res_valid = 1'b1;
      if (c == 80) abort = 1'b1;
      step();
      if (c < 80 && res_exp < 15) res_exp++;
    end
    abort = 1'b0; res_valid = 1'b0;
    total++;
    if (strobes != 20)
      begin bad++; $display("FAIL loop_strobes got=%0d exp=20", strobes); end
    total++;
    if ({busy, done, res_cnt} !== {1'b0, 1'b0, 4'd15})
      begin bad++; $display("FAIL loop_abort got=%h exp=%h", {busy, done, res_cnt}, {1'b0, 1'b0, 4'd15}); end
  endtask

  task automatic test_abort();
    start_run(8, 1'b0);
    for (int c = 0; c <= 13; c++) begin
      total++;
      if ({smp_valid, smp_idx, smp_data} !== exp_smp(c, 8, 1'b0))
        begin bad++; $display("FAIL abort_pre c=%0d got=%h exp=%h", c, {smp_valid, smp_idx, smp_data}, exp_smp(c, 8, 1'b0)); end
      res_valid = (c == 3 || c == 5 || c == 13);
      abort = (c == 13);
      step();
    end
    abort = 1'b0; res_valid = 1'b0;
    total++;
    if ({smp_valid, busy, done, res_cnt} !== {1'b0, 1'b0, 1'b0, 4'd2})
      begin bad++; $display("FAIL abort_edge got=%h exp=%h", {smp_valid, busy, done, res_cnt}, {1'b0, 1'b0, 1'b0, 4'd2}); end
    for (int c = 0; c < 12; c++) begin
      res_valid = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({smp_valid, smp_data, smp_idx, busy, res_cnt} !== {1'b0, 64'd0, 3'd0, 1'b0, 4'd2})
        begin bad++; $display("FAIL abort_after c=%0d got=%h exp=%h", c, {smp_valid, busy, res_cnt}, {1'b0, 1'b0, 4'd2}); end
    end
    res_valid = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    total++;
    if ({busy, smp_valid} !== 2'b00)
      begin bad++; $display("FAIL abort_vs_start got=%b exp=00", {busy, smp_valid}); end
  endtask

  task automatic test_ld_err();
    load_pattern(1'b1);
    start_run(8, 1'b0);
    step(); step();
    ld_en = 1'b1; ld_ch = 1'b0; ld_addr = 3'd0; ld_data = ~mem_m[0][0];
    step();
    ld_en = 1'b0;
    total++;
    if (ld_err !== 1'b1)
      begin bad++; $display("FAIL ld_err_set got=%b exp=1", ld_err); end
    abort_now();
    total++;
    if ({ld_err, busy} !== 2'b10)
      begin bad++; $display("FAIL ld_err_sticky got=%b exp=10", {ld_err, busy}); end
    start_run(1, 1'b0);
    total++;
    if (ld_err !== 1'b0)
      begin bad++; $display("FAIL ld_err_clear got=%b exp=0", ld_err); end
    for (int c = 0; c <= 6; c++) begin
      total++;
      if ({smp_valid, smp_idx, smp_data, ld_err} !== {exp_smp(c, 1, 1'b0), 1'b0})
        begin bad++; $display("FAIL ld_replay c=%0d got=%h exp=%h", c, {smp_valid, smp_idx, smp_data, ld_err}, {exp_smp(c, 1, 1'b0), 1'b0}); end
      step();
    end
    abort_now();
  endtask

  task automatic test_async_reset();
    start_run(8, 1'b0);
    step(); step();
    total++;
    if (smp_valid !== 1'b1)
      begin bad++; $display("FAIL rst_pre got=%b exp=1", smp_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt} !== '0)
      begin bad++; $display("FAIL rst_async got=%h exp=0", {smp_valid, smp_data, smp_idx, busy, done, ld_err, res_cnt}); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if ({smp_valid, busy} !== 2'b00)
        begin bad++; $display("FAIL rst_quiet c=%0d got=%b exp=00", c, {smp_valid, busy}); end
    end
  endtask

  task automatic test_random();
    int n;
    int ne;
    abort_now();
    for (int it = 0; it < 4; it++) begin
      load_pattern(1'b1);
      n  = (it == 0) ? 3 : $urandom_range(0, 15);
      ne = eff_len(n);
      start_run(n, 1'b0);
      for (int c = 0; c <= 2 + K * ne + 1; c++) begin
        total++;
        if ({smp_valid, smp_idx, smp_data, busy, done} !== {exp_smp(c, ne, 1'b0), 1'b1, 1'b0})
          begin bad++; $display("FAIL rand it=%0d n=%0d c=%0d got=%h exp=%h", it, n, c, {smp_valid, smp_idx, smp_data, busy, done}, {exp_smp(c, ne, 1'b0), 1'b1, 1'b0}); end
        step();
      end
      for (int i = 0; i < ne; i++) begin
        res_valid = 1'b1;
        step();
      end
      res_valid = 1'b0;
      total++;
      if ({res_cnt, done} !== {4'(ne), 1'b0})
        begin bad++; $display("FAIL rand_cnt it=%0d got=%h exp=%h", it, {res_cnt, done}, {4'(ne), 1'b0}); end
      step();
      total++;
      if ({busy, done} !== 2'b01)
        begin bad++; $display("FAIL rand_done it=%0d got=%b exp=01", it, {busy, done}); end
    end
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_ch = '0; ld_addr = '0; ld_data = '0;
    start = 1'b0; loop = 1'b0; num_samples = '0; abort = 1'b0; res_valid = 1'b0;
    test_reset();
    test_playback();
    test_results();
    test_loop();
    test_abort();
    test_ld_err();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
